// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples SCLK/SS_N/MOSI on CLOCK_50, shifts words MSB first.
// Latency: 3 CLOCK_50 cycles from an SPI pin change to the internal strobe; rx_valid one cycle after the last rising SCLK.
// Backpressure: one-deep tx holding register (tx_valid/tx_ready); an empty register at word start sends DEFAULT_TX and flags underrun.
//
// Ports:
//   CLOCK_50, RESET           system clock, asynchronous active-high reset
//   SCLK, SS_N, MOSI          SPI inputs from the master, asynchronous to CLOCK_50
//   MISO, MISO_OE             SPI data out and pad enable (enable = selected)
//   tx_data/tx_valid/tx_ready word offered for transmission, accepted when valid & ready
//   rx_data/rx_valid          last received word, rx_valid pulses once per completed word
//   underrun, frame_err       one-cycle event pulses
//   busy                      frame in progress (synchronized SS_N low)

module spi_slave #(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = 8'hFF
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic                  SCLK,
   input  logic                  SS_N,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  MISO_OE,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  underrun,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int                CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // ------------------------------------------------------------------
   // Input synchronizers. Stages [1:0] resolve metastability, stage [2]
   // is the previous synchronized value used for edge detection. MOSI
   // needs no edge detect, so it stops at two stages.
   // ------------------------------------------------------------------
   logic [2:0] sclk_pipe_q, sclk_pipe_d;
   logic [2:0] ss_n_pipe_q, ss_n_pipe_d;
   logic [1:0] mosi_pipe_q, mosi_pipe_d;

   always_comb begin
      sclk_pipe_d = {sclk_pipe_q[1:0], SCLK};
      ss_n_pipe_d = {ss_n_pipe_q[1:0], SS_N};
      mosi_pipe_d = {mosi_pipe_q[0], MOSI};
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         sclk_pipe_q <= 3'b000;
         ss_n_pipe_q <= 3'b111;
         mosi_pipe_q <= 2'b00;
      end else begin
         sclk_pipe_q <= sclk_pipe_d;
         ss_n_pipe_q <= ss_n_pipe_d;
         mosi_pipe_q <= mosi_pipe_d;
      end
   end

   logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_sync;

   always_comb begin
      sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
      sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
      ss_fall   = ~ss_n_pipe_q[1] & ss_n_pipe_q[2];
      ss_rise   = ss_n_pipe_q[1] & ~ss_n_pipe_q[2];
      mosi_sync = mosi_pipe_q[1];
   end

   // ------------------------------------------------------------------
   // Frame state, shift registers and the tx holding register
   // ------------------------------------------------------------------
   logic [0:0]            state_q,       state_d;
   logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
   logic [DATA_WIDTH-1:0] rx_shift_q,    rx_shift_d;
   logic [DATA_WIDTH-1:0] tx_shift_q,    tx_shift_d;
   logic                  word_done_q,   word_done_d;
   logic [DATA_WIDTH-1:0] rx_data_q,     rx_data_d;
   logic                  rx_valid_q,    rx_valid_d;
   logic                  underrun_q,    underrun_d;
   logic                  frame_err_q,   frame_err_d;
   logic [DATA_WIDTH-1:0] hold_q,        hold_d;
   logic                  hold_full_q,   hold_full_d;

   logic                  load_tx;
   logic                  write_acc;
   logic [DATA_WIDTH-1:0] rx_next;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      word_done_d = word_done_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      frame_err_d = 1'b0;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load_tx     = 1'b0;
      write_acc   = tx_valid & ~hold_full_q;
      rx_next     = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};

      case (state_q)
         ST_IDLE: begin
            // SCLK activity while deselected is ignored entirely.
            if (ss_fall) begin
               state_d     = ST_ACTIVE;
               bit_cnt_d   = '0;
               word_done_d = 1'b0;
               rx_shift_d  = '0;
               load_tx     = 1'b1;
            end
         end
         ST_ACTIVE: begin
            // SS_N rise wins over any SCLK edge seen in the same cycle, so a
            // master that drops SCLK and raises SS_N together ends the frame
            // without triggering the next-word load.
            if (ss_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
               word_done_d = 1'b0;
            end else if (sclk_rise) begin
               rx_shift_d = rx_next;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d   = '0;
                  word_done_d = 1'b1;
                  rx_data_d   = rx_next;
                  rx_valid_d  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (sclk_fall) begin
               if (word_done_q) begin
                  // First falling edge after a full word: next word's MSB.
                  word_done_d = 1'b0;
                  load_tx     = 1'b1;
               end else begin
                  tx_shift_d = tx_shift_q << 1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_tx) begin
         if (hold_full_q) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
         end else begin
            tx_shift_d  = DEFAULT_TX;
            underrun_d  = 1'b1;
         end
      end

      // No bypass: a write landing in the same cycle as a load from an
      // empty register is kept for the following word.
      if (write_acc) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         word_done_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         word_done_q <= word_done_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      MISO_OE   = (state_q == ST_ACTIVE);
      busy      = (state_q == ST_ACTIVE);
      MISO      = (state_q == ST_ACTIVE) & tx_shift_q[DATA_WIDTH-1];
      tx_ready  = ~hold_full_q;
      rx_data   = rx_data_q;
      rx_valid  = rx_valid_q;
      underrun  = underrun_q;
      frame_err = frame_err_q;
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives a mode-0 master at CLOCK_50/8 and
// checks MISO bits, received words, event pulses and reset behaviour.
`timescale 1ns/1ps
module tb_spi_slave;

   logic       CLOCK_50 = 1'b0;
   logic       RESET;
   logic       SCLK;
   logic       SS_N;
   logic       MOSI;
   logic       MISO;
   logic       MISO_OE;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       underrun;
   logic       frame_err;
   logic       busy;

   spi_slave #(.DATA_WIDTH(8), .DEFAULT_TX(8'hFF)) dut (
      .CLOCK_50  (CLOCK_50),
      .RESET     (RESET),
      .SCLK      (SCLK),
      .SS_N      (SS_N),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .MISO_OE   (MISO_OE),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .underrun  (underrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;

   // Event monitor, sampled on the falling clock edge.
   int         cyc = 0;
   int         rx_cnt = 0;
   int         underrun_cnt = 0;
   int         underrun_cyc = 0;
   int         frame_err_cnt = 0;
   int         oe_cnt = 0;
   int         ss_fall_cyc = 0;
   logic [7:0] rx_log [0:15];

   always @(negedge CLOCK_50) begin
      cyc = cyc + 1;
      if (rx_valid === 1'b1) begin
         if (rx_cnt < 16) rx_log[rx_cnt] = rx_data;
         rx_cnt = rx_cnt + 1;
      end
      if (underrun === 1'b1) begin
         underrun_cnt = underrun_cnt + 1;
         underrun_cyc = cyc;
      end
      if (frame_err === 1'b1) frame_err_cnt = frame_err_cnt + 1;
      if (MISO_OE === 1'b1) oe_cnt = oe_cnt + 1;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete within 1 ms");
      $fatal(1, "watchdog expired");
   end

   // ---------------- master / fabric primitives ----------------
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic clear_mon();
      rx_cnt        = 0;
      underrun_cnt  = 0;
      frame_err_cnt = 0;
      oe_cnt        = 0;
   endtask

   task automatic ss_low();
      SS_N        = 1'b0;
      ss_fall_cyc = cyc;
      wait_cyc(4);
   endtask

   // The SCLK fall of the previous bit coincides with the new MOSI value.
   task automatic sck_bit(input logic b, output logic m);
      SCLK = 1'b0;
      MOSI = b;
      wait_cyc(4);
      m    = MISO;
      SCLK = 1'b1;
      wait_cyc(4);
   endtask

   task automatic xfer_byte(input logic [7:0] t, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) sck_bit(t[i], r[i]);
   endtask

   // Final SCLK fall and SS_N rise happen together.
   task automatic ss_high();
      SCLK = 1'b0;
      SS_N = 1'b1;
      wait_cyc(8);
   endtask

   task automatic write_tx(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      wait_cyc(1);
      tx_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [14:0] obs;
      RESET = 1'b1; SCLK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0;
      wait_cyc(3);
      obs = {MISO, MISO_OE, tx_ready, rx_data, rx_valid, underrun, frame_err, busy};
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b1, 8'h00, 4'b0000}) begin
         errors++; $display("FAIL reset_outputs: got %b exp %b", obs, {1'b0, 1'b0, 1'b1, 8'h00, 4'b0000});
      end
      RESET = 1'b0;
      wait_cyc(8);
      obs = {MISO, MISO_OE, tx_ready, rx_data, rx_valid, underrun, frame_err, busy};
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b1, 8'h00, 4'b0000}) begin
         errors++; $display("FAIL post_reset_idle: got %b exp %b", obs, {1'b0, 1'b0, 1'b1, 8'h00, 4'b0000});
      end
   endtask

   task automatic test_basic();
      logic [7:0] r;
      clear_mon();
      write_tx(8'hA5);
      checks++;
      if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_tx_ready_full: got %b exp 0", tx_ready); end
      ss_low();
      checks++;
      if ({busy, MISO_OE} !== 2'b11) begin errors++; $display("FAIL basic_busy_oe: got %b exp 11", {busy, MISO_OE}); end
      xfer_byte(8'h3C, r);
      ss_high();
      checks++;
      if (r !== 8'hA5) begin errors++; $display("FAIL basic_miso: got %h exp a5", r); end
      checks++;
      if (rx_cnt !== 1 || rx_log[0] !== 8'h3C) begin
         errors++; $display("FAIL basic_rx: got cnt %0d word %h exp cnt 1 word 3c", rx_cnt, rx_log[0]);
      end
      checks++;
      if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_hold: got %h exp 3c", rx_data); end
      checks++;
      if (underrun_cnt !== 0 || frame_err_cnt !== 0) begin
         errors++; $display("FAIL basic_events: got underrun %0d frame_err %0d exp 0 0", underrun_cnt, frame_err_cnt);
      end
      checks++;
      if ({busy, MISO_OE, tx_ready} !== 3'b001) begin
         errors++; $display("FAIL basic_idle_after: got %b exp 001", {busy, MISO_OE, tx_ready});
      end
   endtask

   task automatic test_underrun();
      logic [7:0] r;
      int         dly;
      clear_mon();
      ss_low();
      xfer_byte(8'h00, r);
      ss_high();
      dly = underrun_cyc - ss_fall_cyc;
      checks++;
      if (r !== 8'hFF) begin errors++; $display("FAIL underrun_miso: got %h exp ff", r); end
      checks++;
      if (underrun_cnt !== 1) begin errors++; $display("FAIL underrun_count: got %0d exp 1", underrun_cnt); end
      checks++;
      if (dly < 1 || dly > 6) begin errors++; $display("FAIL underrun_timing: got %0d cycles after SS_N fall exp 1..6", dly); end
      checks++;
      if (rx_cnt !== 1 || rx_log[0] !== 8'h00) begin
         errors++; $display("FAIL underrun_rx: got cnt %0d word %h exp cnt 1 word 00", rx_cnt, rx_log[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] r0, r1;
      clear_mon();
      write_tx(8'h11);
      fork
         begin
            ss_low();
            xfer_byte(8'hDE, r0);
            xfer_byte(8'hAD, r1);
            ss_high();
         end
         begin
            int n;
            n = 0;
            while (tx_ready !== 1'b1 && n < 100) begin
               wait_cyc(1);
               n++;
            end
            checks++;
            if (n >= 100) begin
               errors++; $display("FAIL b2b_tx_ready_wait: got tx_ready %b after 100 cycles exp 1", tx_ready);
            end else begin
               write_tx(8'h22);
            end
         end
      join
      checks++;
      if ({r0, r1} !== 16'h1122) begin errors++; $display("FAIL b2b_miso: got %h exp 1122", {r0, r1}); end
      checks++;
      if (rx_cnt !== 2 || rx_log[0] !== 8'hDE || rx_log[1] !== 8'hAD) begin
         errors++; $display("FAIL b2b_rx: got cnt %0d words %h %h exp 2 de ad", rx_cnt, rx_log[0], rx_log[1]);
      end
      checks++;
      if (underrun_cnt !== 0) begin errors++; $display("FAIL b2b_underrun: got %0d exp 0", underrun_cnt); end
   endtask

   task automatic test_frame_err();
      logic [7:0] t, r;
      logic       m;
      t = 8'h96;
      clear_mon();
      ss_low();
      for (int i = 7; i >= 3; i--) sck_bit(t[i], m);
      ss_high();
      checks++;
      if (frame_err_cnt !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d exp 1", frame_err_cnt); end
      checks++;
      if (rx_cnt !== 0 || rx_data !== 8'hAD) begin
         errors++; $display("FAIL ferr_rx_kept: got cnt %0d data %h exp 0 ad", rx_cnt, rx_data);
      end
      clear_mon();
      write_tx(8'h3C);
      ss_low();
      xfer_byte(8'h96, r);
      ss_high();
      checks++;
      if (r !== 8'h3C || rx_cnt !== 1 || rx_log[0] !== 8'h96 || frame_err_cnt !== 0) begin
         errors++; $display("FAIL ferr_recover: got miso %h cnt %0d word %h ferr %0d exp 3c 1 96 0",
                            r, rx_cnt, rx_log[0], frame_err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0]  t, r;
      logic        m;
      logic [14:0] obs;
      t = 8'hF0;
      clear_mon();
      write_tx(8'h77);
      ss_low();
      write_tx(8'h42);
      for (int i = 7; i >= 4; i--) sck_bit(t[i], m);
      RESET = 1'b1;
      #1;
      obs = {MISO, MISO_OE, tx_ready, rx_data, rx_valid, underrun, frame_err, busy};
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b1, 8'h00, 4'b0000}) begin
         errors++; $display("FAIL rstmid_async: got %b exp %b", obs, {1'b0, 1'b0, 1'b1, 8'h00, 4'b0000});
      end
      wait_cyc(1);
      obs = {MISO, MISO_OE, tx_ready, rx_data, rx_valid, underrun, frame_err, busy};
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b1, 8'h00, 4'b0000}) begin
         errors++; $display("FAIL rstmid_edge: got %b exp %b", obs, {1'b0, 1'b0, 1'b1, 8'h00, 4'b0000});
      end
      SCLK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
      wait_cyc(2);
      RESET = 1'b0;
      wait_cyc(8);
      clear_mon();
      ss_low();
      xfer_byte(8'h5A, r);
      ss_high();
      checks++;
      if (rx_cnt !== 1 || rx_log[0] !== 8'h5A) begin
         errors++; $display("FAIL rstmid_rx: got cnt %0d word %h exp 1 5a", rx_cnt, rx_log[0]);
      end
      checks++;
      if (r !== 8'hFF || underrun_cnt !== 1 || frame_err_cnt !== 0) begin
         errors++; $display("FAIL rstmid_hold_cleared: got miso %h underrun %0d ferr %0d exp ff 1 0",
                            r, underrun_cnt, frame_err_cnt);
      end
   endtask

   task automatic test_idle_sclk();
      logic [7:0] r;
      clear_mon();
      SS_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         SCLK = 1'b1;
         MOSI = i[0];
         wait_cyc(4);
         SCLK = 1'b0;
         wait_cyc(4);
      end
      checks++;
      if (rx_cnt !== 0 || oe_cnt !== 0 || frame_err_cnt !== 0 || underrun_cnt !== 0) begin
         errors++; $display("FAIL idle_events: got rx %0d oe %0d ferr %0d ur %0d exp 0 0 0 0",
                            rx_cnt, oe_cnt, frame_err_cnt, underrun_cnt);
      end
      checks++;
      if (dut.bit_cnt_q !== 3'd0) begin errors++; $display("FAIL idle_bit_cnt: got %0d exp 0", dut.bit_cnt_q); end
      write_tx(8'hC3);
      ss_low();
      xfer_byte(8'h81, r);
      ss_high();
      checks++;
      if (r !== 8'hC3 || rx_cnt !== 1 || rx_log[0] !== 8'h81) begin
         errors++; $display("FAIL idle_next_frame: got miso %h cnt %0d word %h exp c3 1 81", r, rx_cnt, rx_log[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_back_to_back();
      test_frame_err();
      test_reset_mid();
      test_idle_sclk();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) responder that runs on CLOCK_50 and oversamples the external SCLK, SS_N and MOSI lines.
- It is the far-end counterpart of the board's spi_master: it lets a second board, or a loopback on GPIO_0, answer master transactions.
- Received words go to fabric logic (HEX/LED displays) as one-cycle pulses.
- Transmit words come from fabric through a one-deep holding register with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, bits per SPI word, MSB first.
- DEFAULT_TX, 8'hFF, word shifted out when the holding register is empty at word start (width DATA_WIDTH).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET  input  1  asynchronous, active-high reset.
- SCLK  input  1  SPI clock from the master; asynchronous to CLOCK_50.
- SS_N  input  1  slave select, active low; asynchronous.
- MOSI  input  1  serial data from the master; asynchronous.
- MISO  output  1  serial data to the master.
- MISO_OE  output  1  output enable for the MISO pad; 1 while selected.
- tx_data  input  DATA_WIDTH  word offered for transmission.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty; a write is accepted when tx_valid and tx_ready are both 1.
- rx_data  output  DATA_WIDTH  last complete received word; held until the next word completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- underrun  output  1  one-cycle pulse when DEFAULT_TX is loaded because the holding register is empty.
- frame_err  output  1  one-cycle pulse when SS_N rises in the middle of a word.
- busy  output  1  synchronized SS_N is low.

Behaviour:
- Reset (async, RESET=1) values: MISO=0, MISO_OE=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, frame_err=0, busy=0. Bit counter, shift registers and holding register are cleared, and the synchronizers reset to idle (SCLK=0, SS_N=1, MOSI=0).
- Input path: SCLK, SS_N and MOSI each pass through a 2-flop synchronizer. A third flop provides edge detection (rise/fall strobes of one cycle each).
- Input-path latency: 3 CLOCK_50 cycles. SCLK frequency must be at most CLOCK_50/8, i.e. high and low phases of at least 4 cycles each.
- States: IDLE and ACTIVE.
  - IDLE: MISO_OE=0, busy=0.
  - IDLE -> ACTIVE on the synchronized SS_N falling strobe. In that same cycle: bit_cnt=0, tx_shift loaded from the holding register (tx_ready returns to 1 next cycle), or from DEFAULT_TX with an underrun pulse if the holding register is empty.
  - ACTIVE: MISO_OE=1, busy=1, MISO=tx_shift[MSB] combinationally from the register.
  - ACTIVE -> IDLE on the synchronized SS_N rising strobe. If bit_cnt != 0, frame_err pulses and the partial rx word is discarded (rx_valid is not asserted).
- SCLK rising strobe (ACTIVE only):
  - rx_shift <= {rx_shift[DATA_WIDTH-2:0], MOSI_sync}.
  - bit_cnt increments and wraps at DATA_WIDTH.
  - On the DATA_WIDTH-th rising edge: rx_data takes the complete word in the next cycle, rx_valid pulses for that one cycle, bit_cnt=0, and word_done is set.
- SCLK falling strobe (ACTIVE only):
  - If word_done=1: clear word_done and load tx_shift from the holding register, or from DEFAULT_TX with an underrun pulse (multi-word frames).
  - Otherwise: tx_shift <= tx_shift << 1.
- SCLK edges while in IDLE are ignored.
- Holding register:
  - A write is accepted when tx_valid and tx_ready are both 1; tx_ready drops the next cycle.
  - No bypass: if a write and a load occur in the same cycle with the holding register empty, the write lands in the holding register, the load takes DEFAULT_TX and underrun pulses.
  - A write and a load in the same cycle with the holding register full is impossible, because tx_ready=0.
- Simultaneous SS_N rise and SCLK edge in the same cycle: SS_N takes priority and the edge is ignored.
- Reset mid-frame: all state is cleared at once; the first SS_N fall after reset deassertion starts a clean frame.
- The holding register survives SS_N cycling and is cleared only by RESET or by a load.

Test Plan:
- Reset, then pre-load tx_data=8'hA5. Master sends 8'h3C at CLOCK_50/8 → MISO bits 1,0,1,0,0,1,0,1 sampled on master rising edges; rx_data=8'h3C with a single rx_valid pulse; underrun stays 0.
- No tx write before the frame; master sends 8'h00 → MISO shifts 8'hFF; underrun pulses once, in the SS_N-fall cycle.
- 2-word frame: write 8'h11, then write 8'h22 when tx_ready rises after the first load; master sends 8'hDE, 8'hAD → MISO shows 8'h11 then 8'h22; rx_valid pulses twice with 8'hDE then 8'hAD.
- SS_N raised after 5 bits → frame_err pulse; no rx_valid; rx_data keeps its previous value. The next full frame receives correctly.
- RESET asserted mid-word (bit 4) → all outputs at reset values on the next edge; a following frame with 8'h5A is received correctly.
- SCLK toggling while SS_N=1 → no rx_valid, MISO_OE stays 0, bit_cnt unchanged.
